// File: rtl/adpcm_pcm_fetch_if.sv
// Generic valid/ready read bus used for both the reader-side and memory-side ports
// of adpcm_pcm_fetch. The master drives addr/valid; the slave returns rdata/ready.
interface adpcm_pcm_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output addr, output valid, input rdata, input ready);
  modport slave  (input addr, input valid, output rdata, output ready);
endinterface

// File: rtl/adpcm_pcm_fetch.sv
// One-line PCM byte buffer between the ADPCM-A reader and the memory controller.
// Hit/miss counters are built only when ADPCM_FETCH_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | look up the request every unblocked cycle, serve hits
// S_FILL | sequential word reads refilling the line
module adpcm_pcm_fetch #(
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              stats_clear,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  adpcm_pcm_fetch_if.slave  req,
  adpcm_pcm_fetch_if.master mem
);
  localparam int LB    = 4 * LINE_WORDS;
  localparam int OFF_W = $clog2(LB);
  localparam int WI_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TAG_W = ADDR_W - OFF_W;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t           state;
  logic             line_valid;
  logic             fill_flushed;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      line_q [LINE_WORDS];
  logic [WI_W-1:0]  fill_idx;
  logic [WI_W-1:0]  req_widx;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_word;
  logic             lookup;
  logic             hit;
  logic             miss;
  logic             line_we;

  assign req_tag = req.addr[ADDR_W-1:OFF_W];

  generate
    if (LINE_WORDS > 1) begin : g_widx
      assign req_widx = req.addr[OFF_W-1:2];
    end else begin : g_widx_single
      assign req_widx = '0;
    end
  endgenerate

  assign req_word = line_q[req_widx];

  // The cycle carrying req_ready is skipped: the reader's valid trails its ready.
  assign lookup  = (state == S_IDLE) && req.valid && !req.ready;
  assign hit     = lookup && line_valid && !flush && (tag_q == req_tag);
  assign miss    = lookup && !hit;
  assign line_we = (state == S_FILL) && mem.valid && mem.ready;

  always_ff @(posedge clk) begin
    if (reset_n && line_we) begin
      line_q[fill_idx] <= mem.rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      line_valid   <= 1'b0;
      fill_flushed <= 1'b0;
      tag_q        <= '0;
      fill_idx     <= '0;
      req.rdata    <= '0;
      req.ready    <= 1'b0;
      mem.addr     <= '0;
      mem.valid    <= 1'b0;
    end else begin
      req.ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            line_valid <= 1'b0;
          end
          if (hit) begin
            req.ready <= 1'b1;
            req.rdata <= req_word[{req.addr[1:0], 3'b000} +: 8];
          end else if (miss) begin
            mem.addr     <= {req_tag, {OFF_W{1'b0}}};
            mem.valid    <= 1'b1;
            fill_idx     <= '0;
            fill_flushed <= 1'b0;
            state        <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) begin
            fill_flushed <= 1'b1;
          end
          if (line_we) begin
            mem.valid <= 1'b0;
            if (fill_idx == WI_W'(LINE_WORDS - 1)) begin
              tag_q      <= mem.addr[ADDR_W-1:OFF_W];
              line_valid <= !(fill_flushed || flush);
              state      <= S_IDLE;
            end else begin
              fill_idx <= fill_idx + 1'b1;
              mem.addr <= mem.addr + ADDR_W'(4);
            end
          end else if (!mem.valid) begin
            mem.valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADPCM_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats = stats_clear;
  assign hit_count    = '0;
  assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_adpcm_pcm_fetch.sv
// Scoreboard bench for adpcm_pcm_fetch: a line-level cache model predicts served bytes,
// memory reads and counter values; monitors compare whenever the DUT presents output.
module tb_adpcm_pcm_fetch;
  localparam int ADDR_W     = 24;
  localparam int LINE_WORDS = 2;
  localparam int LB         = 4 * LINE_WORDS;

  logic        clk         = 1'b0;
  logic        reset_n     = 1'b0;
  logic        flush       = 1'b0;
  logic        stats_clear = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks  = 0;
  int errors  = 0;
  int mem_lat = 2;

  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] mexp_q[$];

  bit                m_valid  = 1'b0;
  logic [ADDR_W-1:0] m_base   = '0;
  int                m_hits   = 0;
  int                m_misses = 0;

  adpcm_pcm_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(8))  req_bus ();
  adpcm_pcm_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(32)) mem_bus ();

  adpcm_pcm_fetch #(.LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .stats_clear (stats_clear),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .req         (req_bus.slave),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef ADPCM_FETCH_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("hit_count", {16'd0, hit_count}, cnt_exp(m_hits));
    check("miss_count", {16'd0, miss_count}, cnt_exp(m_misses));
  endtask

  // Memory: every byte holds addr[7:0]; ready rises mem_lat cycles after valid.
  initial begin : mem_model
    int cnt;
    logic [7:0] b;
    cnt = 0;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      tick();
      if (!reset_n || mem_bus.ready) begin
        mem_bus.ready = 1'b0;
        cnt = 0;
      end else if (mem_bus.valid) begin
        cnt++;
        if (cnt >= mem_lat) begin
          b = mem_bus.addr[7:0];
          mem_bus.rdata = {b + 8'd3, b + 8'd2, b + 8'd1, b};
          mem_bus.ready = 1'b1;
        end
      end
    end
  end

  logic              prev_mv = 1'b0;
  logic              prev_hs = 1'b0;
  logic [ADDR_W-1:0] prev_ma = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (req_bus.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req_ready: got rdata 0x%0h, expected no ready", req_bus.rdata);
        end else begin
          check("req_rdata", {24'd0, req_bus.rdata}, {24'd0, exp_q.pop_front()});
        end
      end
      if (mem_bus.valid) begin
        if (prev_mv && !prev_hs) check("mem_addr_stable", {8'd0, mem_bus.addr}, {8'd0, prev_ma});
        if (mexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_valid: got addr 0x%0h, expected no memory request", mem_bus.addr);
        end else if (mem_bus.ready) begin
          check("mem_addr", {8'd0, mem_bus.addr}, {8'd0, mexp_q.pop_front()});
        end
      end
      prev_mv = mem_bus.valid;
      prev_hs = mem_bus.valid && mem_bus.ready;
      prev_ma = mem_bus.addr;
    end else begin
      prev_mv = 1'b0;
      prev_hs = 1'b0;
    end
  end

  // Line-level model: lookups repeat until a hit serves the byte (or the reader leaves).
  task automatic model_txn(input logic [ADDR_W-1:0] a, input bit fs, input bit ffill,
                           input bit abandon, output bit first_hit);
    logic [ADDR_W-1:0] base;
    bit ff;
    base = a & ~ADDR_W'(LB - 1);
    ff = ffill;
    first_hit = 1'b0;
    if (fs) m_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_valid && m_base == base) begin
        if (k == 0) first_hit = 1'b1;
        if (m_hits < 65535) m_hits++;
        exp_q.push_back(a[7:0]);
        break;
      end
      if (m_misses < 65535) m_misses++;
      for (int w = 0; w < LINE_WORDS; w++) mexp_q.push_back(base + ADDR_W'(4 * w));
      m_base = base;
      m_valid = !ff;
      ff = 1'b0;
      if (abandon) break;
    end
  endtask

  task automatic txn(input logic [ADDR_W-1:0] a, input bit fs, input bit ffill,
                     input bit abandon, input int lag, input bit sc);
    bit fh;
    int cyc;
    model_txn(a, fs, ffill, abandon, fh);
    if (sc) begin
      m_hits = 0;
      m_misses = 0;
    end
    req_bus.addr = a;
    req_bus.valid = 1'b1;
    flush = fs;
    stats_clear = sc;
    tick();
    flush = 1'b0;
    stats_clear = 1'b0;
    cyc = 1;
    if (ffill || abandon) begin
      while (!mem_bus.valid && cyc < 20) begin
        tick();
        cyc++;
      end
      check("fill_start", {31'd0, mem_bus.valid}, 32'd1);
      if (ffill) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end else begin
        tick();
        req_bus.valid = 1'b0;
        cyc = 0;
        while ((mexp_q.size() != 0 || mem_bus.valid) && cyc < 200) begin
          tick();
          cyc++;
        end
        repeat (3) tick();
        check("abandon_mem_done", mexp_q.size(), 32'd0);
        check("abandon_no_ready", exp_q.size(), 32'd0);
        check_counts();
        return;
      end
    end
    while (!req_bus.ready && cyc < 200) begin
      tick();
      cyc++;
    end
    check("req_ready_seen", {31'd0, req_bus.ready}, 32'd1);
    if (fh) check("hit_latency", cyc, 32'd1);
    repeat (lag) tick();
    req_bus.valid = 1'b0;
    tick();
    check("req_q_drained", exp_q.size(), 32'd0);
    check("mem_q_drained", mexp_q.size(), 32'd0);
    check_counts();
  endtask

  initial begin : main
    bit fh;
    int cyc;
    logic [ADDR_W-1:0] pool [4];
    logic [ADDR_W-1:0] a;
    bit would_hit, fs, ffill, abandon;
    int r;

    req_bus.addr = '0;
    req_bus.valid = 1'b0;
    repeat (3) tick();
    check("rst_req_rdata", {24'd0, req_bus.rdata}, 32'd0);
    check("rst_req_ready", {31'd0, req_bus.ready}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_bus.addr}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_bus.valid}, 32'd0);
    check("rst_hit_count", {16'd0, hit_count}, 32'd0);
    check("rst_miss_count", {16'd0, miss_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    txn(24'h000105, 0, 0, 0, 0, 0);
    txn(24'h000106, 0, 0, 0, 0, 0);
    txn(24'h000107, 0, 0, 0, 1, 0);
    txn(24'h002000, 0, 0, 1, 0, 0);
    txn(24'h002003, 0, 0, 0, 0, 0);
    txn(24'h003005, 0, 1, 0, 0, 0);

    // Reset while a fill is outstanding.
    model_txn(24'h004001, 0, 0, 0, fh);
    req_bus.addr = 24'h004001;
    req_bus.valid = 1'b1;
    cyc = 0;
    while (!mem_bus.valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("pre_reset_fill", {31'd0, mem_bus.valid}, 32'd1);
    reset_n = 1'b0;
    req_bus.valid = 1'b0;
    tick();
    check("reset_mem_valid", {31'd0, mem_bus.valid}, 32'd0);
    check("reset_req_ready", {31'd0, req_bus.ready}, 32'd0);
    check("reset_hit_count", {16'd0, hit_count}, 32'd0);
    check("reset_miss_count", {16'd0, miss_count}, 32'd0);
    exp_q.delete();
    mexp_q.delete();
    m_valid = 1'b0;
    m_hits = 0;
    m_misses = 0;
    reset_n = 1'b1;
    tick();
    txn(24'h000105, 0, 0, 0, 0, 0);

    txn(24'h000102, 1, 0, 0, 0, 0);
    flush = 1'b1;
    m_valid = 1'b0;
    tick();
    flush = 1'b0;
    txn(24'h000103, 0, 0, 0, 1, 0);
    txn(24'h000104, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) pool[i] = ADDR_W'($urandom()) & ~ADDR_W'(LB - 1);
    for (int i = 0; i < 300; i++) begin
      mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        m_valid = 1'b0;
        tick();
        flush = 1'b0;
      end
      a = pool[$urandom_range(0, 3)] | ADDR_W'($urandom_range(0, LB - 1));
      fs = ($urandom_range(0, 9) == 0);
      would_hit = !fs && m_valid && ((a & ~ADDR_W'(LB - 1)) == m_base);
      r = $urandom_range(0, 7);
      ffill = !would_hit && (r == 0);
      abandon = !would_hit && !fs && (r == 1);
      txn(a, fs, ffill, abandon, $urandom_range(0, 1), 0);
    end

`ifdef ADPCM_FETCH_STATS_EN
    mem_lat = 1;
    force dut.miss_count = 16'hFFFD;
    #1;
    release dut.miss_count;
    m_misses = 65533;
    for (int i = 0; i < 4; i++) begin
      txn(24'h010000 + ADDR_W'(i * LB), 0, 0, 0, 0, 0);
    end
    check("miss_count_saturated", {16'd0, miss_count}, 32'h0000FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adpcm_pcm_fetch.md
Name: adpcm_pcm_fetch

Overview:
- Sits directly downstream of the ADPCM-A reader's PCM data port (`pcm_mem_addr`, `pcm_mem_valid`, `pcm_mem_rdata`, `pcm_mem_ready`).
- Serves single-byte PCM reads from a one-line buffer and fills that buffer with sequential 32-bit reads from the flash/memory controller.
- ADPCM-A reads are mostly sequential, so most bytes are served without memory traffic. This frees memory bandwidth for ADPCM-B and the CPU.

Parameters:
- LINE_WORDS, 2, number of 32-bit words per line. Must be a power of 2, at least 1. Line size in bytes is LB = 4*LINE_WORDS.
- ADDR_W, 24, byte address width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- req_addr  input  ADDR_W  byte address from the reader.
- req_valid  input  1  read request. Level signal; may drop before req_ready (reader paused).
- req_rdata  output  8  returned byte.
- req_ready  output  1  one-cycle pulse; req_rdata is valid in the same cycle.
- flush  input  1  single-cycle pulse; invalidates the line.
- mem_addr  output  ADDR_W  word-aligned memory address, bits [1:0] = 0.
- mem_valid  output  1  memory request.
- mem_rdata  input  32  memory data, little-endian.
- mem_ready  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- stats_clear  input  1  clears hit_count and miss_count.
- hit_count  output  16  saturating hit counter.
- miss_count  output  16  saturating miss counter.

Behaviour:
- Reset (reset_n low on a clk edge): state goes to S_IDLE and line_valid=0. All outputs are 0: req_rdata, req_ready, mem_addr, mem_valid, hit_count, miss_count.
- Reset takes effect immediately, including mid-fill; the in-flight memory transaction is abandoned. The memory controller shares this reset.
- Tag is req_addr[ADDR_W-1:log2(LB)]. A hit requires line_valid and a tag match.
- S_IDLE:
  - Evaluates req_valid every cycle except the cycle in which req_ready is high. That cycle is a blocked cycle because the reader's valid lags its ready by one cycle.
  - Hit at cycle T: at T+1, req_ready=1 and req_rdata = line byte req_addr[log2(LB)-1:0]. Stay in S_IDLE.
  - Miss at T: latch the line base (req_addr with the low log2(LB) bits cleared) and zero the word index. Go to S_FILL; mem_valid=1 at T+1.
- Within a word, byte n (n = addr[1:0]) is mem_rdata[8n+7:8n].
- S_FILL:
  - mem_valid is held high with mem_addr stable until mem_ready.
  - On mem_ready, store the word at the current index and drop mem_valid for exactly one cycle.
  - Then re-assert mem_valid with mem_addr += 4 for the next word.
  - After the last word (index LINE_WORDS-1): write the tag, set line_valid=1, return to S_IDLE. The next cycle's S_IDLE lookup serves the request.
  - Miss latency is therefore fill time + 2 cycles.
  - req_valid and req_addr are ignored during S_FILL; no req_ready is ever issued from S_FILL.
- Abandoned request: if req_valid drops mid-fill, the fill still completes and the line becomes valid. No req_ready is issued unless req_valid is high in S_IDLE afterwards.
- Address changed mid-fill: the S_IDLE lookup after the fill uses the current req_addr and may miss again.
- flush:
  - In S_IDLE: clears line_valid at the next edge. Flush takes priority over a same-cycle lookup, which is treated as a miss.
  - In S_FILL: the fill completes, but line_valid stays 0. The following lookup misses and refills.
- req_rdata holds its last value between ready pulses.
- Counters:
  - On a hit decision, hit_count+1; on a miss decision, miss_count+1. Both saturate at 0xFFFF.
  - stats_clear has priority over an increment in the same cycle.

Optional Feature:
- ADPCM_FETCH_STATS_EN defined: hit_count and miss_count behave as described above.
- Undefined: the counter logic is not built; hit_count and miss_count are tied to 0 and stats_clear is ignored.

Test Plan:
- Memory model: every byte's value equals its addr[7:0]. mem_ready is asserted 2 cycles after mem_valid rises. LINE_WORDS=2. ADPCM_FETCH_STATS_EN is defined.
- After reset, req 0x000105 -> mem reads at 0x000100 then 0x000104. Then req_ready with req_rdata=0x05; miss_count=1.
- Then req 0x000106, then 0x000107 (valid dropped after each ready) -> no mem_valid. Each req_ready arrives 1 cycle after valid; rdata is 0x06 then 0x07; hit_count=2.
- Req 0x002000, with req_valid dropped 1 cycle into the fill -> both mem reads complete and no req_ready. Then req 0x002003 -> hit, rdata=0x03, no mem traffic.
- Req 0x003005 with flush pulsed during the first mem read -> 4 mem reads total (0x003000, 0x003004, 0x003000, 0x003004). Then req_ready with rdata=0x05; miss_count increments by 2.
- Drive reset_n low while mem_valid=1 -> the next cycle mem_valid=0 and both counters are 0. Then re-request 0x000105 -> misses (line invalid).
- stats_clear asserted together with a hit -> hit_count=0 the next cycle. Force 65535 misses -> miss_count stays at 0xFFFF on further misses.
